hash_table_requester: RTL and testbench



---
 rtl/hash_table_pkg.sv | 24 ++
 rtl/sat_counter.sv | 19 +
 rtl/hash_table_requester.sv | 151 +++++++++++++++
 tb/tb_hash_table_requester.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_table_pkg.sv
// Shared definitions for the hash table and its requester front end:
// operation encodings, requester FSM states and a width helper.
package hash_table_pkg;

    typedef enum logic [1:0] {
        OP_INSERT  = 2'b00,
        OP_DELETE  = 2'b01,
        OP_SEARCH  = 2'b10,
        OP_INVALID = 2'b11
    } ht_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } req_state_e;

    // Collision counter width; clamped to 1 so tiny chain depths still give a legal port.
    function automatic int coll_width(input int chaining_size);
        return (chaining_size > 2) ? $clog2(chaining_size - 1) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hash_table_requester.sv
// Initiator-side front end for the hash table command interface: one operation
// in flight, operands held for its duration, timeout guard and statistics.
module hash_table_requester
    import hash_table_pkg::*;
#(
    parameter int KEY_WIDTH      = 32,
    parameter int VALUE_WIDTH    = 32,
    parameter int CHAINING_SIZE  = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int STAT_WIDTH     = 16,
    localparam int COLL_WIDTH    = coll_width(CHAINING_SIZE)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [KEY_WIDTH-1:0]   req_key,
    input  logic [VALUE_WIDTH-1:0] req_value,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [1:0]             rsp_op,
    output logic [VALUE_WIDTH-1:0] rsp_value,
    output logic                   rsp_error,
    output logic                   rsp_timeout,
    output logic [COLL_WIDTH-1:0]  rsp_collision_count,
    output logic [KEY_WIDTH-1:0]   ht_key,
    output logic [VALUE_WIDTH-1:0] ht_value,
    output logic [1:0]             ht_op_sel,
    output logic                   ht_op_en,
    input  logic [VALUE_WIDTH-1:0] ht_value_out,
    input  logic                   ht_op_done,
    input  logic                   ht_op_error,
    input  logic [COLL_WIDTH-1:0]  ht_collision_count,
    output logic [STAT_WIDTH-1:0]  stat_ops,
    output logic [STAT_WIDTH-1:0]  stat_errors,
    output logic [STAT_WIDTH-1:0]  stat_stale
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    req_state_e       state, state_next;
    logic [TMO_W-1:0] tmo_cnt;
    logic             ready_en;
    logic             req_fire;
    logic             tmo_last;

    // ready_en keeps req_ready low for the first cycle out of reset.
    assign req_ready = (state == ST_IDLE) && ready_en;
    assign req_fire  = req_valid && req_ready;
    assign ht_op_en  = (state == ST_ISSUE);
    assign rsp_valid = (state == ST_RESP);
    assign rsp_op    = ht_op_sel;
    assign tmo_last  = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (req_fire) begin
                    state_next = (req_op == OP_INVALID) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                if (ht_op_done || tmo_last) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_en            <= 1'b0;
            tmo_cnt             <= '0;
            ht_key              <= '0;
            ht_value            <= '0;
            ht_op_sel           <= '0;
            rsp_value           <= '0;
            rsp_error           <= 1'b0;
            rsp_timeout         <= 1'b0;
            rsp_collision_count <= '0;
        end else begin
            ready_en <= 1'b1;
            if (req_fire) begin
                ht_key              <= req_key;
                ht_value            <= req_value;
                ht_op_sel           <= req_op;
                rsp_value           <= '0;
                rsp_error           <= (req_op == OP_INVALID);
                rsp_timeout         <= 1'b0;
                rsp_collision_count <= '0;
            end
            if (state == ST_ISSUE) begin
                tmo_cnt <= '0;
            end
            // A completion on the final waiting cycle takes priority over the timeout.
            if (state == ST_WAIT) begin
                if (ht_op_done) begin
                    rsp_value           <= ((ht_op_sel == OP_SEARCH) && !ht_op_error) ? ht_value_out : '0;
                    rsp_error           <= ht_op_error;
                    rsp_collision_count <= ht_collision_count;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (tmo_last) begin
                        rsp_error   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_value   <= '0;
                    end
                end
            end
        end
    end

    sat_counter #(.WIDTH(STAT_WIDTH)) u_stat_ops (
        .clk   (clk),
        .clr   (rst),
        .inc   ((state == ST_WAIT) && ht_op_done),
        .count (stat_ops)
    );

    sat_counter #(.WIDTH(STAT_WIDTH)) u_stat_errors (
        .clk   (clk),
        .clr   (rst),
        .inc   (rsp_valid && rsp_ready && rsp_error),
        .count (stat_errors)
    );

    sat_counter #(.WIDTH(STAT_WIDTH)) u_stat_stale (
        .clk   (clk),
        .clr   (rst),
        .inc   (ht_op_done && (state != ST_WAIT)),
        .count (stat_stale)
    );

endmodule

// File: tb/tb_hash_table_requester.sv
// Bench for hash_table_requester: a behavioural table plus a transaction-level
// expectation queue, checked every cycle, with literal expectations per response.
module tb_hash_table_requester;
    import hash_table_pkg::*;

    localparam int KW = 32;
    localparam int VW = 32;
    localparam int CS = 4;
    localparam int TO = 8;
    localparam int SW = 16;
    localparam int CW = coll_width(CS);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b00;
    logic [KW-1:0] req_key = '0;
    logic [VW-1:0] req_value = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [1:0]    rsp_op;
    logic [VW-1:0] rsp_value;
    logic          rsp_error;
    logic          rsp_timeout;
    logic [CW-1:0] rsp_collision_count;
    logic [KW-1:0] ht_key;
    logic [VW-1:0] ht_value;
    logic [1:0]    ht_op_sel;
    logic          ht_op_en;
    logic [VW-1:0] ht_value_out = '0;
    logic          ht_op_done = 1'b0;
    logic          ht_op_error = 1'b0;
    logic [CW-1:0] ht_collision_count = '0;
    logic [SW-1:0] stat_ops, stat_errors, stat_stale;

    hash_table_requester #(
        .KEY_WIDTH      (KW),
        .VALUE_WIDTH    (VW),
        .CHAINING_SIZE  (CS),
        .TIMEOUT_CYCLES (TO),
        .STAT_WIDTH     (SW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_op              (req_op),
        .req_key             (req_key),
        .req_value           (req_value),
        .rsp_valid           (rsp_valid),
        .rsp_ready           (rsp_ready),
        .rsp_op              (rsp_op),
        .rsp_value           (rsp_value),
        .rsp_error           (rsp_error),
        .rsp_timeout         (rsp_timeout),
        .rsp_collision_count (rsp_collision_count),
        .ht_key              (ht_key),
        .ht_value            (ht_value),
        .ht_op_sel           (ht_op_sel),
        .ht_op_en            (ht_op_en),
        .ht_value_out        (ht_value_out),
        .ht_op_done          (ht_op_done),
        .ht_op_error         (ht_op_error),
        .ht_collision_count  (ht_collision_count),
        .stat_ops            (stat_ops),
        .stat_errors         (stat_errors),
        .stat_stale          (stat_stale)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]    op;
        logic [VW-1:0] value;
        logic          err;
        logic          tmo;
        logic [CW-1:0] coll;
        int            due;
    } rsp_t;

    function automatic rsp_t mk(input logic [1:0] op, input logic [VW-1:0] value,
                                input logic err, input logic tmo,
                                input logic [CW-1:0] coll, input int due);
        rsp_t r;
        r.op = op; r.value = value; r.err = err; r.tmo = tmo; r.coll = coll; r.due = due;
        return r;
    endfunction

    // Stimulus-side controls (written only by the stimulus process).
    int            lat = 3;
    bit            hang = 1'b0;
    int            stale_req = 0;
    bit            lit_on = 1'b0;
    logic [1:0]    lit_op;
    logic [VW-1:0] lit_value;
    logic          lit_err, lit_tmo;
    logic [CW-1:0] lit_coll;
    int            lit_seq = 0;
    int            lit_ops, lit_errs, lit_stale;

    // Model state (written only by the checker process).
    rsp_t          q[$];
    logic [VW-1:0] table_mem [logic [KW-1:0]];
    bit            outstanding = 1'b0;
    bit            pend = 1'b0;
    bit            rst_prev = 1'b1;
    int            exp_en_cyc = -1;
    int            wait_end = -1;
    int            done_at = 0;
    logic [KW-1:0] m_key = '0;
    logic [VW-1:0] m_val = '0;
    logic [1:0]    m_op = '0;
    int            m_ops = 0, m_errs = 0, m_stale = 0;
    int            stale_done = 0;
    int            lit_done = 0;
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        bit            exp_valid, exp_ready, hit, e;
        logic [VW-1:0] v;
        logic [CW-1:0] co;

        exp_valid = (q.size() > 0) && (q[0].due <= cyc);
        exp_ready = !outstanding && !rst_prev;
        chk("rsp_valid", rsp_valid, exp_valid);
        if (exp_valid) begin
            chk("rsp_op", rsp_op, q[0].op);
            chk("rsp_value", rsp_value, q[0].value);
            chk("rsp_error", rsp_error, q[0].err);
            chk("rsp_timeout", rsp_timeout, q[0].tmo);
            chk("rsp_coll", rsp_collision_count, q[0].coll);
        end
        chk("req_ready", req_ready, exp_ready);
        chk("ht_op_en", ht_op_en, cyc == exp_en_cyc);
        chk("ht_key", ht_key, m_key);
        chk("ht_value", ht_value, m_val);
        chk("ht_op_sel", ht_op_sel, m_op);
        chk("stat_ops", stat_ops, m_ops);
        chk("stat_errors", stat_errors, m_errs);
        chk("stat_stale", stat_stale, m_stale);
        if (rst_prev) begin
            chk("rst_rsp_op", rsp_op, 0);
            chk("rst_rsp_value", rsp_value, 0);
            chk("rst_rsp_error", rsp_error, 0);
            chk("rst_rsp_timeout", rsp_timeout, 0);
            chk("rst_rsp_coll", rsp_collision_count, 0);
        end
        if (lit_seq != lit_done) begin
            chk("lit_stat_ops", stat_ops, lit_ops);
            chk("lit_stat_errors", stat_errors, lit_errs);
            chk("lit_stat_stale", stat_stale, lit_stale);
            lit_done = lit_seq;
        end

        ht_op_done = 1'b0;
        ht_op_error = 1'b0;
        ht_value_out = '0;
        ht_collision_count = '0;

        if (rst) begin
            q.delete();
            outstanding = 1'b0;
            pend = 1'b0;
            exp_en_cyc = -1;
            wait_end = -1;
            m_key = '0; m_val = '0; m_op = '0;
            m_ops = 0; m_errs = 0; m_stale = 0;
            rst_prev = 1'b1;
        end else begin
            rst_prev = 1'b0;
            if (exp_valid && rsp_ready) begin
                if (lit_on) begin
                    chk("lit_rsp_op", rsp_op, lit_op);
                    chk("lit_rsp_value", rsp_value, lit_value);
                    chk("lit_rsp_error", rsp_error, lit_err);
                    chk("lit_rsp_timeout", rsp_timeout, lit_tmo);
                    chk("lit_rsp_coll", rsp_collision_count, lit_coll);
                end
                if (q[0].err) m_errs++;
                void'(q.pop_front());
                outstanding = 1'b0;
            end
            if (req_valid && exp_ready) begin
                outstanding = 1'b1;
                m_key = req_key; m_val = req_value; m_op = req_op;
                if (req_op == OP_INVALID) begin
                    q.push_back(mk(OP_INVALID, '0, 1'b1, 1'b0, '0, cyc + 1));
                end else begin
                    exp_en_cyc = cyc + 1;
                    if (hang) begin
                        wait_end = cyc + TO;
                        q.push_back(mk(req_op, '0, 1'b1, 1'b1, '0, cyc + 1 + TO));
                    end else begin
                        pend = 1'b1;
                        done_at = cyc + 1 + lat;
                        wait_end = done_at;
                    end
                end
            end
            if (pend && (cyc == done_at)) begin
                hit = table_mem.exists(m_key);
                co = m_key[CW-1:0];
                v = '0;
                e = 1'b0;
                case (m_op)
                    OP_INSERT: table_mem[m_key] = m_val;
                    OP_DELETE: begin
                        e = !hit;
                        if (hit) table_mem.delete(m_key);
                    end
                    default: begin
                        e = !hit;
                        if (hit) v = table_mem[m_key];
                        ht_value_out = hit ? v : 32'hBAD0_0BAD;
                    end
                endcase
                ht_op_done = 1'b1;
                ht_op_error = e;
                ht_collision_count = co;
                q.push_back(mk(m_op, v, e, 1'b0, co, cyc + 1));
                m_ops++;
                pend = 1'b0;
            end
            if (stale_req != stale_done) begin
                stale_done = stale_req;
                ht_op_done = 1'b1;
                ht_value_out = '1;
                if (!((cyc > exp_en_cyc) && (cyc <= wait_end))) m_stale++;
            end
        end
    end

    task automatic set_lit(input logic [1:0] op, input logic [VW-1:0] value,
                           input logic err, input logic tmo, input logic [CW-1:0] coll);
        lit_on = 1'b1;
        lit_op = op; lit_value = value; lit_err = err; lit_tmo = tmo; lit_coll = coll;
    endtask

    task automatic lit_stats(input int ops, input int errs, input int stale);
        @(posedge clk); #1;
        lit_ops = ops; lit_errs = errs; lit_stale = stale;
        lit_seq++;
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [KW-1:0] key, input logic [VW-1:0] value);
        bit ok;
        ok = 1'b0;
        req_valid = 1'b1; req_op = op; req_key = key; req_value = value;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!ok) begin
            $display("FAIL send_accept: got req_ready=0 expected 1 within 50 cycles");
            $fatal(1, "request never accepted");
        end
    endtask

    task automatic wait_rsp(input int hold);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            $display("FAIL wait_rsp: got rsp_valid=0 expected 1 within 60 cycles");
            $fatal(1, "response never arrived");
        end
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        lit_stats(0, 0, 0);

        lat = 3;
        set_lit(OP_INSERT, '0, 1'b0, 1'b0, 2'd1);
        send(OP_INSERT, 32'h0000_0005, 32'hDEAD_BEEF);
        wait_rsp(0);
        set_lit(OP_SEARCH, 32'hDEAD_BEEF, 1'b0, 1'b0, 2'd1);
        send(OP_SEARCH, 32'h0000_0005, '0);
        wait_rsp(0);
        lit_stats(2, 0, 0);

        set_lit(OP_SEARCH, '0, 1'b1, 1'b0, 2'd3);
        send(OP_SEARCH, 32'h0000_0013, 32'h0000_FFFF);
        wait_rsp(0);
        lit_stats(3, 1, 0);

        set_lit(OP_INVALID, '0, 1'b1, 1'b0, 2'd0);
        send(OP_INVALID, 32'h0000_0007, '0);
        wait_rsp(0);
        lit_stats(3, 2, 0);

        hang = 1'b1;
        set_lit(OP_SEARCH, '0, 1'b1, 1'b1, 2'd0);
        send(OP_SEARCH, 32'h0000_0020, '0);
        wait_rsp(0);
        hang = 1'b0;
        lit_stats(3, 3, 0);
        stale_req++;
        repeat (5) @(posedge clk);
        #1;
        lit_stats(3, 3, 1);

        set_lit(OP_INSERT, '0, 1'b0, 1'b0, 2'd0);
        send(OP_INSERT, 32'h0000_0040, 32'h0000_1234);
        wait_rsp(0);
        set_lit(OP_SEARCH, 32'h0000_1234, 1'b0, 1'b0, 2'd0);
        send(OP_SEARCH, 32'h0000_0040, '0);
        wait_rsp(10);
        lit_stats(5, 3, 1);

        lat = 7;
        set_lit(OP_INSERT, '0, 1'b0, 1'b0, 2'd1);
        send(OP_INSERT, 32'h0000_0009, 32'h0000_A5A5);
        wait_rsp(0);
        lat = 1;
        set_lit(OP_DELETE, '0, 1'b0, 1'b0, 2'd1);
        send(OP_DELETE, 32'h0000_0009, '0);
        wait_rsp(0);
        set_lit(OP_DELETE, '0, 1'b1, 1'b0, 2'd1);
        send(OP_DELETE, 32'h0000_0009, '0);
        wait_rsp(0);
        lit_stats(8, 4, 1);

        lat = 6;
        lit_on = 1'b0;
        send(OP_SEARCH, 32'h0000_0005, '0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        lit_stats(0, 0, 0);

        lat = 3;
        set_lit(OP_INSERT, '0, 1'b0, 1'b0, 2'd3);
        send(OP_INSERT, 32'h0000_0077, 32'h0000_0055);
        wait_rsp(0);
        lit_stats(1, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
